// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use hazard
// detection and a saturating count of hazard bubbles.
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [3:0]  id_gin,
    input  logic        id_alusrc,
    input  logic        id_regdst,
    input  logic        id_uses_rt,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_memwrite,
    input  logic        id_memtoreg,
    input  logic        exmem_regwrite,
    input  logic        memwb_regwrite,
    input  logic [4:0]  exmem_rd,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] exmem_result,
    input  logic [31:0] memwb_result,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_gin,
    output logic [31:0] ex_store_data,
    output logic        ex_valid,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic        ex_memtoreg,
    output logic [4:0]  ex_dest,
    output logic        load_use_hazard,
    output logic [15:0] bubble_count
);

    typedef struct packed {
        logic        valid;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [3:0]  gin;
        logic        alusrc;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
    } stage_t;

    localparam logic [3:0] GIN_ADD = 4'b0010;

    stage_t      stage_q;
    stage_t      stage_d;
    stage_t      id_pkt;
    stage_t      bubble_pkt;
    logic [15:0] bubble_count_q;
    logic [15:0] bubble_count_d;
    logic        hazard;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    // Pick the newest in-flight value of a register; $0 is never forwarded.
    function automatic logic [31:0] forward(
        input logic [4:0]  rn,
        input logic [31:0] rdata,
        input logic        em_we,
        input logic [4:0]  em_rd,
        input logic [31:0] em_res,
        input logic        mw_we,
        input logic [4:0]  mw_rd,
        input logic [31:0] mw_res
    );
        logic [31:0] v;
        v = rdata;
        if (rn != 5'd0) begin
            if (em_we && em_rd == rn) begin
                v = em_res;
            end else if (mw_we && mw_rd == rn) begin
                v = mw_res;
            end
        end
        return v;
    endfunction

    // Pack the decoded ID slot and the bubble template.
    always_comb begin
        id_pkt          = '0;
        id_pkt.valid    = in_valid;
        id_pkt.rs_data  = id_rs_data;
        id_pkt.rt_data  = id_rt_data;
        id_pkt.imm      = id_imm;
        id_pkt.rs       = id_rs;
        id_pkt.rt       = id_rt;
        id_pkt.dest     = id_regdst ? id_rd : id_rt;
        id_pkt.gin      = id_gin;
        id_pkt.alusrc   = id_alusrc;
        id_pkt.regwrite = id_regwrite;
        id_pkt.memread  = id_memread;
        id_pkt.memwrite = id_memwrite;
        id_pkt.memtoreg = id_memtoreg;
        bubble_pkt      = '0;
        bubble_pkt.gin  = GIN_ADD;
    end

    // A load in EX whose target is read by the ID instruction.
    always_comb begin
        hazard = 1'b0;
        if (in_valid && stage_q.valid && stage_q.memread &&
            stage_q.dest != 5'd0) begin
            hazard = (stage_q.dest == id_rs) ||
                     (id_uses_rt && stage_q.dest == id_rt);
        end
    end

    // Next-state select: flush > stall > hazard bubble > load.
    always_comb begin
        stage_d        = stage_q;
        bubble_count_d = bubble_count_q;
        if (flush) begin
            stage_d = bubble_pkt;
        end else if (stall) begin
            stage_d = stage_q;
        end else if (hazard) begin
            stage_d = bubble_pkt;
            if (bubble_count_q != 16'hFFFF) begin
                bubble_count_d = bubble_count_q + 16'd1;
            end
        end else begin
            stage_d = id_pkt;
        end
    end

    // Stage registers; reset yields a bubble with a zero ALU control.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q        <= '0;
            bubble_count_q <= '0;
        end else begin
            stage_q        <= stage_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    // Operand forwarding, recomputed every cycle including stalls.
    always_comb begin
        fwd_rs = forward(stage_q.rs, stage_q.rs_data,
                         exmem_regwrite, exmem_rd, exmem_result,
                         memwb_regwrite, memwb_rd, memwb_result);
        fwd_rt = forward(stage_q.rt, stage_q.rt_data,
                         exmem_regwrite, exmem_rd, exmem_result,
                         memwb_regwrite, memwb_rd, memwb_result);
    end

    assign alu_a           = fwd_rs;
    assign alu_b           = stage_q.alusrc ? stage_q.imm : fwd_rt;
    assign ex_store_data   = fwd_rt;
    assign alu_gin         = stage_q.gin;
    assign ex_valid        = stage_q.valid;
    assign ex_regwrite     = stage_q.regwrite;
    assign ex_memread      = stage_q.memread;
    assign ex_memwrite     = stage_q.memwrite;
    assign ex_memtoreg     = stage_q.memtoreg;
    assign ex_dest         = stage_q.dest;
    assign load_use_hazard = hazard;
    assign bubble_count    = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver queues expected outputs,
// a negedge monitor pops and compares them.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, in_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [3:0]  id_gin;
    logic        id_alusrc, id_regdst, id_uses_rt;
    logic        id_regwrite, id_memread, id_memwrite, id_memtoreg;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_gin;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite;
    logic        ex_memtoreg, load_use_hazard;
    logic [4:0]  ex_dest;
    logic [15:0] bubble_count;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] st;
        logic [3:0]  gin;
        logic        v;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        mtr;
        logic [4:0]  dest;
        logic        hz;
        logic [15:0] bc;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_gin(id_gin), .id_alusrc(id_alusrc), .id_regdst(id_regdst),
        .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_memtoreg(id_memtoreg),
        .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_result(exmem_result), .memwb_result(memwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_gin(alu_gin),
        .ex_store_data(ex_store_data), .ex_valid(ex_valid),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .ex_dest(ex_dest), .load_use_hazard(load_use_hazard),
        .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(
        input logic [31:0] a, input logic [31:0] b, input logic [31:0] st,
        input logic [3:0] gin, input logic v, input logic rw,
        input logic mr, input logic mw, input logic mtr,
        input logic [4:0] dest, input logic hz, input logic [15:0] bc
    );
        exp_t e;
        e.a = a; e.b = b; e.st = st; e.gin = gin; e.v = v; e.rw = rw;
        e.mr = mr; e.mw = mw; e.mtr = mtr; e.dest = dest; e.hz = hz;
        e.bc = bc;
        return e;
    endfunction

    // lw $9, 8($4) sitting in EX with no forwarding active
    function automatic exp_t exp_lw(input logic hz, input logic [15:0] bc);
        return mk(32'd100, 32'd8, 32'd0, 4'b0010, 1, 1, 1, 0, 1,
                  5'd9, hz, bc);
    endfunction

    function automatic exp_t exp_bub(input logic [3:0] g,
                                     input logic [15:0] bc);
        return mk(0, 0, 0, g, 0, 0, 0, 0, 0, 5'd0, 0, bc);
    endfunction

    task automatic set_id(
        input logic v, input logic [4:0] rs, input logic [4:0] rt,
        input logic [4:0] rd, input logic [31:0] rsd,
        input logic [31:0] rtd, input logic [31:0] imm,
        input logic [3:0] gin, input logic alusrc, input logic regdst,
        input logic uses_rt, input logic rw, input logic mr,
        input logic mw, input logic mtr
    );
        in_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_gin = gin;
        id_alusrc = alusrc; id_regdst = regdst; id_uses_rt = uses_rt;
        id_regwrite = rw; id_memread = mr; id_memwrite = mw;
        id_memtoreg = mtr;
    endtask

    task automatic id_lw9();
        set_id(1, 5'd4, 5'd9, 5'd0, 32'd100, 32'd0, 32'd8, 4'b0010,
               1, 0, 0, 1, 1, 0, 1);
    endtask

    task automatic id_use9();
        set_id(1, 5'd9, 5'd2, 5'd10, 32'h11, 32'h22, 32'd0, 4'b0010,
               0, 1, 1, 1, 0, 0, 0);
    endtask

    task automatic fw(
        input logic erw, input logic [4:0] erd, input logic [31:0] eres,
        input logic mrw, input logic [4:0] mrd, input logic [31:0] mres
    );
        exmem_regwrite = erw; exmem_rd = erd; exmem_result = eres;
        memwb_regwrite = mrw; memwb_rd = mrd; memwb_result = mres;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every negedge, compare the DUT against the queued entry.
    always @(negedge clk) begin
        exp_t e;
        exp_t act;
        if (q.size() > 0) begin
            e = q.pop_front();
            act = mk(alu_a, alu_b, ex_store_data, alu_gin, ex_valid,
                     ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
                     ex_dest, load_use_hazard, bubble_count);
            vectors++;
            if (act !== e) begin
                miscompares++;
                $display("FAIL vec%0d: got a=%h b=%h st=%h gin=%b v=%b rw=%b mr=%b mw=%b mtr=%b dest=%0d hz=%b bc=%h; want a=%h b=%h st=%h gin=%b v=%b rw=%b mr=%b mw=%b mtr=%b dest=%0d hz=%b bc=%h",
                    vectors, act.a, act.b, act.st, act.gin, act.v, act.rw,
                    act.mr, act.mw, act.mtr, act.dest, act.hz, act.bc,
                    e.a, e.b, e.st, e.gin, e.v, e.rw, e.mr, e.mw, e.mtr,
                    e.dest, e.hz, e.bc);
            end
        end
    end

    initial begin
        logic [15:0] bc;
        int          waited;
        reset = 1; stall = 0; flush = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
        fw(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        // reset state; load add rs=1(5) rt=2(7) rd=3
        reset = 0;
        set_id(1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 4'b0010,
               0, 1, 1, 1, 0, 0, 0);
        q.push_back(exp_bub(4'b0000, 16'd0));
        next();
        id_lw9();
        q.push_back(mk(5, 7, 7, 4'b0010, 1, 1, 0, 0, 0, 5'd3, 0, 0));
        next();
        id_use9();
        q.push_back(exp_lw(1, 16'd0));
        next();
        q.push_back(exp_bub(4'b0010, 16'd1));
        next();
        // use9 in EX; $9 arrives from MEM/WB
        fw(0, 0, 0, 1, 5'd9, 32'h99);
        set_id(1, 5'd8, 5'd8, 5'd8, 32'h55, 32'h66, 32'd0, 4'b0110,
               0, 1, 1, 1, 0, 0, 0);
        q.push_back(mk(32'h99, 32'h22, 32'h22, 4'b0010, 1, 1, 0, 0, 0,
                       5'd10, 0, 1));
        next();
        // EX/MEM beats MEM/WB, then stall and watch forwarding track
        fw(1, 5'd8, 32'hAA, 1, 5'd8, 32'hBB);
        stall = 1;
        q.push_back(mk(32'hAA, 32'hAA, 32'hAA, 4'b0110, 1, 1, 0, 0, 0,
                       5'd8, 0, 1));
        next();
        fw(0, 5'd8, 32'hAA, 1, 5'd8, 32'hBB);
        set_id(1, 5'd0, 5'd0, 5'd0, 32'h77, 32'h88, 32'd0, 4'b0100,
               0, 0, 1, 0, 0, 1, 0);
        q.push_back(mk(32'hBB, 32'hBB, 32'hBB, 4'b0110, 1, 1, 0, 0, 0,
                       5'd8, 0, 1));
        for (int i = 1; i <= 3; i++) begin
            next();
            fw(1, 5'd8, i, 0, 0, 0);
            q.push_back(mk(i, i, i, 4'b0110, 1, 1, 0, 0, 0, 5'd8, 0, 1));
        end
        next();
        // writers target $0: no forwarding
        stall = 0;
        fw(1, 5'd0, 32'hEE, 1, 5'd0, 32'hFF);
        q.push_back(mk(32'h55, 32'h66, 32'h66, 4'b0110, 1, 1, 0, 0, 0,
                       5'd8, 0, 1));
        next();
        id_lw9();
        q.push_back(mk(32'h77, 32'h88, 32'h88, 4'b0100, 1, 0, 0, 1, 0,
                       5'd0, 0, 1));
        next();
        // flush + stall + hazard together
        fw(0, 0, 0, 0, 0, 0);
        id_use9();
        flush = 1; stall = 1;
        q.push_back(exp_lw(1, 16'd1));
        next();
        flush = 0; stall = 0;
        id_lw9();
        q.push_back(exp_bub(4'b0010, 16'd1));
        next();
        // hazard under stall holds; then reset during the stall
        id_use9();
        stall = 1;
        q.push_back(exp_lw(1, 16'd1));
        next();
        reset = 1;
        q.push_back(exp_lw(1, 16'd1));
        next();
        reset = 0; stall = 0;
        id_lw9();
        q.push_back(exp_bub(4'b0000, 16'd0));
        // counting hazard bubbles
        bc = 16'd0;
        for (int i = 0; i < 3; i++) begin
            next();
            id_use9();
            q.push_back(exp_lw(1, bc));
            bc = bc + 16'd1;
            next();
            id_lw9();
            q.push_back(exp_bub(4'b0010, bc));
        end
        // saturation: preload near the top, then keep hazarding
        for (int i = 0; i < 4; i++) begin
            next();
            if (i == 0) begin
                force dut.bubble_count_q = 16'hFFFD;
                #1;
                release dut.bubble_count_q;
                bc = 16'hFFFD;
            end
            id_use9();
            q.push_back(exp_lw(1, bc));
            if (bc != 16'hFFFF) bc = bc + 16'd1;
            next();
            id_lw9();
            q.push_back(exp_bub(4'b0010, bc));
        end
        next();
        in_valid = 0;
        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  synchronous, active-high reset.
REQ-002 SHALL have ports: stall  in  1  hold stage contents; flush  in  1  replace next contents with bubble; in_valid  in  1  ID slot holds an instruction.
REQ-003 SHALL have ports: id_rs_data, id_rt_data, id_imm  in  32 each  register-file reads and sign-extended immediate.
REQ-004 SHALL have ports: id_rs, id_rt, id_rd  in  5 each  register specifiers.
REQ-005 SHALL have ports: id_gin  in  4  ALU control line; id_alusrc, id_regdst, id_uses_rt, id_regwrite, id_memread, id_memwrite, id_memtoreg  in  1 each  decoded controls.
REQ-006 SHALL have ports: exmem_regwrite, memwb_regwrite  in  1; exmem_rd, memwb_rd  in  5; exmem_result, memwb_result  in  32  forwarding sources.
REQ-007 SHALL have ports: alu_a, alu_b  out  32  ALU operands; alu_gin  out  4  ALU control line; ex_store_data  out  32  forwarded rt for stores.
REQ-008 SHALL have ports: ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  1; ex_dest  out  5; load_use_hazard  out  1; bubble_count  out  16.

Function
REQ-009 SHALL register on each rising clk edge, when not held: rs_data, rt_data, imm, rs, rt, gin, alusrc, and all controls; ex_dest SHALL be registered as id_regdst ? id_rd : id_rt.
REQ-010 SHALL update registers each cycle, with priority reset > flush > stall > hazard > load.
REQ-011 Load: registers take ID values; ex_valid <= in_valid.
REQ-012 Stall (flush=0): all registers SHALL hold their values.
REQ-013 Bubble (flush=1, or load_use_hazard=1 with stall=0): ex_valid, regwrite, memread, memwrite, memtoreg, alusrc <= 0; ex_dest <= 0; gin <= 4'b0010; data registers <= 0.
REQ-014 SHALL assert load_use_hazard combinationally when in_valid & ex_valid & ex_memread & ex_dest!=0 & (ex_dest==id_rs | (id_uses_rt & ex_dest==id_rt)).
REQ-015 SHALL assert load_use_hazard only as an output; upstream holds ID using it, and the block inserts exactly one bubble per hazard cycle per REQ-013.
REQ-016 SHALL compute the forwarded rs value combinationally from the registered value:
- exmem_result if exmem_regwrite & exmem_rd!=0 & exmem_rd==reg_rs;
- else memwb_result if memwb_regwrite & memwb_rd!=0 & memwb_rd==reg_rs;
- else reg_rs_data.
REQ-017 SHALL compute the forwarded rt value the same way with reg_rt; EX/MEM SHALL always win over MEM/WB.
REQ-018 SHALL drive alu_a = forwarded rs; alu_b = reg_alusrc ? reg_imm : forwarded rt; ex_store_data = forwarded rt; alu_gin = reg_gin.
REQ-019 SHALL recompute forwarding every cycle, including stalled cycles, so held operands pick up newly arriving results.
REQ-020 SHALL never forward register 0; operands naming $0 SHALL pass registered data unchanged.
REQ-021 SHALL increment bubble_count by 1 on each cycle a bubble is inserted due to load_use_hazard; flush-induced bubbles SHALL NOT count.
REQ-022 SHALL saturate bubble_count at 16'hFFFF with no wrap.
REQ-023 SHALL impose no handshake latency: ID contents SHALL appear on outputs one cycle after the loading edge.

Reset
REQ-024 When reset=1 at a rising edge, SHALL behave as a bubble (REQ-013) except gin <= 4'b0000, and SHALL set bubble_count <= 0.
REQ-025 Reset SHALL override flush, stall and hazard on the same edge, including in the middle of a stall.
REQ-026 After reset, with no forwarding active, SHALL drive alu_a=0, alu_b=0, alu_gin=0000, ex_valid=0 and load_use_hazard=0.

Verification
REQ-027 Load add with rs_data=5, rt_data=7, gin=0010, alusrc=0, no forwarding -> next cycle alu_a=5, alu_b=7, alu_gin=0010, ex_valid=1.
REQ-028 Registered rs=8, exmem_rd=8, memwb_rd=8 both writing, exmem_result=0xAA, memwb_result=0xBB -> alu_a=0xAA; with exmem_regwrite=0 -> alu_a=0xBB; with rs=0 -> registered data.
REQ-029 EX holds lw to $9 and ID reads rs=9 -> load_use_hazard=1; next cycle ex_valid=0, gin=0010, bubble_count=1.
REQ-030 Stall=1 for 3 cycles with exmem_result changing 1,2,3 on a matching rd -> registers held, alu_a follows 1,2,3.
REQ-031 flush=1 together with stall=1 and a hazard -> bubble inserted, bubble_count unchanged; reset asserted during a stall -> outputs per REQ-026 on the next cycle.
REQ-032 Force 65536 hazard bubbles -> bubble_count stays at 0xFFFF.
